// File: rtl/prep_ctrl_pkg.sv
// Shared opcodes, ALU operation codes and the control bundle for the PREP
// prefix sequencer.
package prep_ctrl_pkg;

  localparam int unsigned OPC_W = 3;
  localparam int unsigned ALU_W = 3;

  // Base-mode opcodes
  localparam logic [OPC_W-1:0] OP_PREP   = 3'b000;
  localparam logic [OPC_W-1:0] OP_INCDEC = 3'b001;
  localparam logic [OPC_W-1:0] OP_XOR    = 3'b010;
  localparam logic [OPC_W-1:0] OP_XORR   = 3'b011;
  localparam logic [OPC_W-1:0] OP_SLL    = 3'b100;
  localparam logic [OPC_W-1:0] OP_SRL    = 3'b101;

  // Prefix-mode opcodes share encodings with the base set
  localparam logic [OPC_W-1:0] OP_ANDI   = 3'b000;
  localparam logic [OPC_W-1:0] OP_BEQ    = 3'b001;
  localparam logic [OPC_W-1:0] OP_LW     = 3'b010;
  localparam logic [OPC_W-1:0] OP_SW     = 3'b011;
  localparam logic [OPC_W-1:0] OP_SAVE   = 3'b100;
  localparam logic [OPC_W-1:0] OP_PSFT   = 3'b101;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_RXOR = 3'b011,
    ALU_SLL  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_AND  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  localparam alu_op_e ALU_INC = ALU_ADD;
  localparam alu_op_e ALU_DEC = ALU_SUB;

  typedef struct packed {
    logic    wprep;
    logic    rprep;
    logic    we;
    logic    dw;
    logic    dr;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{wprep: 1'b0, rprep: 1'b0, we: 1'b0,
                                  dw: 1'b0, dr: 1'b0, alu_op: ALU_ADD};

endpackage

// File: rtl/prep_ctrl_decode.sv
// Combinational instruction decode: {prefix_active, opcode, lastBit} to
// control bundle plus PSFT / illegal flags.
module prep_ctrl_decode
  import prep_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3
) (
  input  logic                prefix_active_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                last_bit_i,
  output ctrl_t               ctrl_o,
  output logic                is_psft_o,
  output logic                is_illegal_o
);

  always_comb begin
    ctrl_o       = CTRL_IDLE;
    is_psft_o    = 1'b0;
    is_illegal_o = 1'b0;
    if (!prefix_active_i) begin
      case (opcode_i)
        OPCODE_W'(OP_PREP): begin
          ctrl_o.wprep = 1'b1;
          ctrl_o.we    = 1'b1;
        end
        OPCODE_W'(OP_INCDEC): begin
          ctrl_o.we     = 1'b1;
          ctrl_o.alu_op = last_bit_i ? ALU_INC : ALU_DEC;
        end
        OPCODE_W'(OP_XOR): begin
          ctrl_o.we     = 1'b1;
          ctrl_o.alu_op = ALU_XOR;
        end
        OPCODE_W'(OP_XORR): begin
          ctrl_o.we     = 1'b1;
          ctrl_o.alu_op = ALU_RXOR;
        end
        OPCODE_W'(OP_SLL): begin
          ctrl_o.we     = 1'b1;
          ctrl_o.alu_op = ALU_SLL;
        end
        OPCODE_W'(OP_SRL): begin
          ctrl_o.we     = 1'b1;
          ctrl_o.alu_op = ALU_SRL;
        end
        default: is_illegal_o = 1'b1;
      endcase
    end else begin
      // Every legal prefixed instruction consumes the prep register
      ctrl_o.rprep = 1'b1;
      case (opcode_i)
        OPCODE_W'(OP_ANDI): begin
          ctrl_o.we     = 1'b1;
          ctrl_o.alu_op = ALU_AND;
        end
        OPCODE_W'(OP_BEQ): begin
          ctrl_o.alu_op = ALU_XOR;
        end
        OPCODE_W'(OP_LW): begin
          ctrl_o.we     = 1'b1;
          ctrl_o.dr     = 1'b1;
          ctrl_o.alu_op = ALU_ADD;
        end
        OPCODE_W'(OP_SW): begin
          ctrl_o.dw     = 1'b1;
          ctrl_o.alu_op = ALU_ADD;
        end
        OPCODE_W'(OP_SAVE): begin
          ctrl_o.we     = 1'b1;
          ctrl_o.alu_op = ALU_PASS;
        end
        OPCODE_W'(OP_PSFT): begin
          ctrl_o.wprep  = 1'b1;
          ctrl_o.we     = 1'b1;
          ctrl_o.alu_op = ALU_SLL;
          is_psft_o     = 1'b1;
        end
        default: begin
          ctrl_o.rprep = 1'b0;
          is_illegal_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/prep_ctrl_sequencer.sv
// Multi-level PREP/PSFT prefix sequencer: zero-latency control decode with
// prefix level, accumulated immediate and sticky illegal-opcode flag.
module prep_ctrl_sequencer
  import prep_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 3,
  parameter int unsigned IMM_W      = 5,
  parameter int unsigned PREP_DEPTH = 2,
  parameter int unsigned ALUOP_W    = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              instr_valid_i,
  input  logic                              stall_i,
  input  logic [OPCODE_W+IMM_W-1:0]         instr_i,
  input  logic                              err_clear_i,
  output logic                              write_prep_reg_o,
  output logic                              read_prep_reg_o,
  output logic                              write_enabled_o,
  output logic                              data_write_o,
  output logic                              data_read_o,
  output logic [ALUOP_W-1:0]                alu_op_o,
  output logic [PREP_DEPTH*IMM_W-1:0]       prep_imm_o,
  output logic [$clog2(PREP_DEPTH+1)-1:0]   prep_level_o,
  output logic                              illegal_o,
  output logic                              err_sticky_o
);

  localparam int unsigned PW    = PREP_DEPTH * IMM_W;
  localparam int unsigned LVL_W = $clog2(PREP_DEPTH + 1);

  logic [LVL_W-1:0]    level_q, level_d;
  logic [PW-1:0]       imm_q, imm_d;
  logic                err_q, err_d;

  logic [OPCODE_W-1:0] opcode_c;
  logic [IMM_W-1:0]    imm_c;
  logic                fire_c;
  logic                prefix_c;
  logic                overflow_c;
  logic                illegal_c;
  ctrl_t               dec_ctrl_c;
  ctrl_t               ctrl_c;
  logic                dec_psft_c;
  logic                dec_illegal_c;

  assign opcode_c = instr_i[OPCODE_W+IMM_W-1:IMM_W];
  assign imm_c    = instr_i[IMM_W-1:0];
  assign prefix_c = (level_q != '0);
  // Reset is folded into fire so control outputs read 0 while held in reset
  assign fire_c   = instr_valid_i & ~stall_i & reset;

  prep_ctrl_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .prefix_active_i (prefix_c),
    .opcode_i        (opcode_c),
    .last_bit_i      (imm_c[0]),
    .ctrl_o          (dec_ctrl_c),
    .is_psft_o       (dec_psft_c),
    .is_illegal_o    (dec_illegal_c)
  );

  // A PSFT at full depth would overflow the prefix chain
  assign overflow_c = dec_psft_c & (level_q == LVL_W'(PREP_DEPTH));
  assign illegal_c  = fire_c & (dec_illegal_c | overflow_c);

  always_comb begin
    ctrl_c = CTRL_IDLE;
    if (fire_c && !illegal_c) begin
      ctrl_c = dec_ctrl_c;
    end
  end

  assign write_prep_reg_o = ctrl_c.wprep;
  assign read_prep_reg_o  = ctrl_c.rprep;
  assign write_enabled_o  = ctrl_c.we;
  assign data_write_o     = ctrl_c.dw;
  assign data_read_o      = ctrl_c.dr;
  assign alu_op_o         = ALUOP_W'(ctrl_c.alu_op);
  assign illegal_o        = illegal_c;
  assign prep_imm_o       = imm_q;
  assign prep_level_o     = level_q;
  assign err_sticky_o     = err_q;

  always_comb begin
    level_d = level_q;
    imm_d   = imm_q;
    err_d   = err_q;
    if (illegal_c) begin
      level_d = '0;
      imm_d   = '0;
    end else if (fire_c) begin
      if (!prefix_c) begin
        if (opcode_c == OPCODE_W'(OP_PREP)) begin
          level_d = LVL_W'(1);
          imm_d   = PW'(imm_c);
        end
      end else if (dec_psft_c) begin
        level_d = level_q + LVL_W'(1);
        imm_d   = (imm_q << IMM_W) | PW'(imm_c);
      end else begin
        level_d = '0;
        imm_d   = '0;
      end
    end
    // Set wins over a same-cycle clear
    if (illegal_c) begin
      err_d = 1'b1;
    end else if (err_clear_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      imm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_prep_ctrl_sequencer.sv
// Self-checking bench for prep_ctrl_sequencer: directed scenarios plus
// randomized instruction streams against a table-driven reference model.
module tb_prep_ctrl_sequencer;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       stall;
  logic [7:0] instr;
  logic       err_clear;
  logic       wprep, rprep, we, dw, dr;
  logic [2:0] alu_op;
  logic [9:0] prep_imm;
  logic [1:0] prep_level;
  logic       illegal;
  logic       err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_lvl;
  logic [9:0] m_imm;
  bit         m_err;

  prep_ctrl_sequencer dut (
    .clk              (clk),
    .reset            (rst_n),
    .instr_valid_i    (instr_valid),
    .stall_i          (stall),
    .instr_i          (instr),
    .err_clear_i      (err_clear),
    .write_prep_reg_o (wprep),
    .read_prep_reg_o  (rprep),
    .write_enabled_o  (we),
    .data_write_o     (dw),
    .data_read_o      (dr),
    .alu_op_o         (alu_op),
    .prep_imm_o       (prep_imm),
    .prep_level_o     (prep_level),
    .illegal_o        (illegal),
    .err_sticky_o     (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction table: enables {wprep,rprep,we,dw,dr}, ALU code, illegal
  function automatic void ref_decode(input int lvl, input logic [2:0] op, input bit lb,
                                     output logic [4:0] en, output logic [2:0] alu,
                                     output bit ill);
    en = 5'b0; alu = 3'd0; ill = 1'b0;
    if (lvl == 0) begin
      case (op)
        3'd0: begin en = 5'b10100; alu = 3'd0; end
        3'd1: begin en = 5'b00100; alu = lb ? 3'd0 : 3'd1; end
        3'd2: begin en = 5'b00100; alu = 3'd2; end
        3'd3: begin en = 5'b00100; alu = 3'd3; end
        3'd4: begin en = 5'b00100; alu = 3'd4; end
        3'd5: begin en = 5'b00100; alu = 3'd5; end
        default: ill = 1'b1;
      endcase
    end else begin
      case (op)
        3'd0: begin en = 5'b01100; alu = 3'd6; end
        3'd1: begin en = 5'b01000; alu = 3'd2; end
        3'd2: begin en = 5'b01101; alu = 3'd0; end
        3'd3: begin en = 5'b01010; alu = 3'd0; end
        3'd4: begin en = 5'b01100; alu = 3'd7; end
        3'd5: if (lvl < DEPTH) begin en = 5'b11100; alu = 3'd4; end
              else ill = 1'b1;
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      en  = 5'b0;
      alu = 3'd0;
    end
  endfunction

  task automatic model_reset();
    m_lvl = 0;
    m_imm = '0;
    m_err = 1'b0;
  endtask

  // One instruction slot: drive at negedge, check, then advance the model at posedge
  task automatic step(input bit v, input bit s, input logic [2:0] op, input logic [4:0] imm,
                      input bit clr);
    bit         fire, ill;
    logic [4:0] en;
    logic [2:0] alu;
    @(negedge clk);
    instr_valid = v;
    stall       = s;
    instr       = {op, imm};
    err_clear   = clr;
    #1;
    fire = v && !s;
    ref_decode(m_lvl, op, imm[0], en, alu, ill);
    if (!fire) begin
      en = 5'b0; alu = 3'd0; ill = 1'b0;
    end
    chk("enables", 32'({wprep, rprep, we, dw, dr}), 32'(en));
    if (!ill) chk("alu_op", 32'(alu_op), 32'(alu));
    chk("illegal", 32'(illegal), 32'(ill));
    chk("prep_imm", 32'(prep_imm), 32'(m_imm));
    chk("level", 32'(prep_level), 32'(m_lvl));
    chk("err_sticky", 32'(err_sticky), 32'(m_err));
    @(posedge clk);
    if (fire) begin
      if (ill) begin
        m_lvl = 0; m_imm = '0;
      end else if (m_lvl == 0) begin
        if (op == 3'd0) begin
          m_lvl = 1; m_imm = 10'(imm);
        end
      end else if (op == 3'd5) begin
        m_imm = 10'((m_imm << 5) | 10'(imm));
        m_lvl = m_lvl + 1;
      end else begin
        m_lvl = 0; m_imm = '0;
      end
    end
    if (fire && ill) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    #1;
    instr_valid = 1'b0;
    err_clear   = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int lvl, input logic [9:0] imm,
                            input bit err);
    @(negedge clk);
    #1;
    chk({tag, "_level"}, 32'(prep_level), 32'(lvl));
    chk({tag, "_imm"}, 32'(prep_imm), 32'(imm));
    chk({tag, "_err"}, 32'(err_sticky), 32'(err));
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    stall       = 1'b0;
    instr       = {3'd2, 5'h1F};
    #1;
    chk("rst_enables", 32'({wprep, rprep, we, dw, dr}), 32'd0);
    chk("rst_alu", 32'(alu_op), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_imm", 32'(prep_imm), 32'd0);
    chk("rst_level", 32'(prep_level), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    model_reset();
    idle_check("post_rst", 0, 10'h000, 1'b0);
  endtask

  initial begin
    logic [2:0] op;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    instr       = '0;
    err_clear   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_check("reset", 0, 10'h000, 1'b0);

    // PREP 0x03 then LW
    step(1, 0, 3'd0, 5'h03, 0);
    idle_check("after_prep", 1, 10'h003, 1'b0);
    step(1, 0, 3'd2, 5'h00, 0);
    idle_check("after_lw", 0, 10'h000, 1'b0);

    // PREP 0x01, PSFT 0x1F, SW
    step(1, 0, 3'd0, 5'h01, 0);
    step(1, 0, 3'd5, 5'h1F, 0);
    idle_check("after_psft", 2, 10'h03F, 1'b0);
    step(1, 0, 3'd3, 5'h00, 0);

    // Depth overflow, then clear
    step(1, 0, 3'd0, 5'h02, 0);
    step(1, 0, 3'd5, 5'h04, 0);
    step(1, 0, 3'd5, 5'h06, 0);
    idle_check("after_ovf", 0, 10'h000, 1'b1);
    step(0, 0, 3'd0, 5'h00, 1);
    idle_check("after_clr", 0, 10'h000, 1'b0);

    // Stall held in prefix mode, then ANDI
    step(1, 0, 3'd0, 5'h0A, 0);
    repeat (4) step(1, 1, 3'd2, 5'h00, 0);
    idle_check("stalled", 1, 10'h00A, 1'b0);
    step(1, 0, 3'd0, 5'h00, 0);

    // INC / DEC, then illegal with concurrent clear
    step(1, 0, 3'd1, 5'h01, 0);
    step(1, 0, 3'd1, 5'h00, 0);
    step(1, 0, 3'd7, 5'h00, 1);
    idle_check("set_wins", 0, 10'h000, 1'b1);

    // Reset mid-prefix with err set
    step(1, 0, 3'd0, 5'h11, 0);
    reset_mid_run();

    // Randomized stream
    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset_mid_run();
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = 3'd0;
      step($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, op,
           5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prep_ctrl_sequencer.md
Name: prep_ctrl_sequencer

Overview:
- Parametrised successor to the single-level PREP control decoder.
- Decodes each instruction into datapath control: register-file write, prep-register read/write, data-memory read/write and ALU operation.
- Tracks a multi-level prefix mode: PREP followed by up to PREP_DEPTH-1 chained PSFTs, with the immediate accumulated internally and presented when a prefixed instruction consumes it.
- Sits between the instruction fetch register and the register file/ALU/data-memory controls; adds a valid/stall handshake and illegal-opcode reporting.

Parameters:
- OPCODE_W, 3, opcode field width (upper bits of instr_i).
- IMM_W, 5, immediate/register field width (lower bits of instr_i); bit 0 is lastBit.
- PREP_DEPTH, 2, maximum prefix levels (PREP counts as 1); minimum 1.
- ALUOP_W, 3, ALU operation code width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid_i  in  1  instr_i holds a valid instruction this cycle.
- stall_i  in  1  pipeline hold; instruction is not consumed.
- instr_i  in  OPCODE_W+IMM_W  {opcode, imm}.
- err_clear_i  in  1  clears err_sticky_o.
- write_prep_reg_o  out  1  write prep register.
- read_prep_reg_o  out  1  operand taken from prep register.
- write_enabled_o  out  1  register-file write enable.
- data_write_o  out  1  data-memory store.
- data_read_o  out  1  data-memory load.
- alu_op_o  out  ALUOP_W  ALU operation.
- prep_imm_o  out  PREP_DEPTH*IMM_W  accumulated prefix immediate.
- prep_level_o  out  $clog2(PREP_DEPTH+1)  current prefix level, 0 = base mode.
- illegal_o  out  1  single-cycle pulse: illegal instruction consumed.
- err_sticky_o  out  1  latched illegal flag.

Behaviour:
- Reset (reset low, asynchronous): level=0, prep_imm=0, err_sticky=0. All outputs read 0 while reset is low.
- Fire = instr_valid_i && !stall_i. State updates only on fire.
- When fire is low: all enables, illegal_o=0 and alu_op_o=ALU_ADD. prep_imm_o and prep_level_o still reflect state.
- Decode is combinational from {level, opcode, lastBit}, so control has zero-cycle latency; state changes on the next rising edge.
- Base mode (level 0):
  - 000 PREP: wprep=1, we=1; next level=1, prep_imm<=zero-extended imm.
  - 001 INC/DEC: we=1; alu=INC if lastBit=1, else DEC.
  - 010 XOR: we=1, alu=XOR.
  - 011 XORR: we=1, alu=RXOR.
  - 100 SLL: we=1, alu=SLL.
  - 101 SRL: we=1, alu=SRL.
  - 110/111: illegal.
- Prefix mode (level>=1). Every legal opcode except PSFT sets rprep=1 and returns to level 0:
  - 000 ANDI: we=1, alu=AND.
  - 001 BEQ: we=0, alu=XOR.
  - 010 LW: we=1, dr=1, alu=ADD.
  - 011 SW: dw=1, alu=ADD.
  - 100 SAVE: we=1, alu=PASS.
  - 101 PSFT: wprep=1, rprep=1, we=1, alu=SLL. If level<PREP_DEPTH: prep_imm<=(prep_imm<<IMM_W)|imm, level++. If level==PREP_DEPTH: illegal.
  - 110/111: illegal.
- Illegal instruction: all enables 0, illegal_o=1 that cycle, err_sticky<=1, level<=0, prep_imm<=0.
- prep_imm_o is stable and valid during the consuming instruction's cycle. It clears to 0 on the edge after that instruction.
- err_clear_i together with a new illegal fire in the same cycle: set wins.
- Stall while in prefix mode: level and prep_imm hold indefinitely.
- Reset asserted mid-prefix: prefix is abandoned and state returns to reset values.
- All values are unsigned. Shifts discard high bits beyond PREP_DEPTH*IMM_W (cannot occur when depth is respected).

Decomposition:
- Package prep_ctrl_pkg: opcode localparams for both modes (OP_PREP/OP_ANDI=000, ... OP_SRL/OP_PSFT=101).
- ALU op enum: ADD/INC=000, SUB/DEC=001, XOR=010, RXOR=011, SLL=100, SRL=101, AND=110, PASS=111.
- Control bundle struct {wprep, rprep, we, dw, dr, alu_op}.
- One sub-module, prep_ctrl_decode: purely combinational, maps {prefix_active, opcode, lastBit} to {control struct, is_psft, is_illegal}.
- The top level holds level, prep_imm, err_sticky and the fire/gating logic.

Test Plan:
- Reset low mid-run, then release -> all outputs 0 during reset; level=0, err_sticky=0 after release.
- PREP imm=5'h03, then LW -> PREP cycle: wprep=1, we=1. LW cycle: rprep=1, dr=1, we=1, alu=000, prep_imm_o=10'h003. Next cycle: level=0, prep_imm_o=0.
- PREP 5'h01, PSFT 5'h1F, SW (PREP_DEPTH=2) -> prep_level_o 1 then 2. During SW: prep_imm_o=10'h03F, dw=1, we=0.
- PREP, PSFT, PSFT (PREP_DEPTH=2) -> second PSFT: illegal_o pulse, all enables 0, err_sticky=1, level=0. Then err_clear_i -> err_sticky=0.
- PREP, then instr_valid with stall_i=1 for 4 cycles, then ANDI -> enables 0 while stalled, level stays 1. ANDI: rprep=1, we=1, alu=110.
- Base INC with lastBit=1 and =0, then opcode 111 with err_clear_i=1 same cycle -> alu 000, then 001; illegal_o=1 and err_sticky=1 (set wins).
